shft_ser_ctrl: RTL

- Serializer controller sitting directly upstream of the W-bit universal shift register datapath.
- Accepts a parallel word over a valid/ready handshake, then drives the register's en/load_sel/dir_sel/p_in to load the word and shift it out.
- Presents the outgoing serial bit from the register's parallel output at a programmable bit rate.
- Pulses done when the frame completes.

---
 rtl/shft_pkg.sv | 27 ++
 rtl/shft_ser_ctrl_if.sv | 45 ++++
 rtl/shft_tick_div.sv | 43 ++++
 rtl/shft_ser_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/shft_pkg.sv
// ---------------------------------------------------------------------------
// shft_pkg
// Shared definitions for the serializer controller that drives the
// universal shift register datapath.
//   state_t        controller state encoding (IDLE/LOAD/SHIFT/DONE)
//   DIR_MSB_FIRST  direction code for left shift, MSB leaves first
//   DIR_LSB_FIRST  direction code for right shift, LSB leaves first
//   len_width()    width of the frame-length field for a given data width
// ---------------------------------------------------------------------------
package shft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // One extra bit over log2 so that a length of exactly W is representable.
    function automatic int len_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/shft_ser_ctrl_if.sv
// ---------------------------------------------------------------------------
// shft_ser_ctrl_if
// Upstream word handshake for the serializer controller.
//   in_valid  word offered by upstream
//   in_ready  controller can accept a word
//   in_data   W-bit word to serialize
//   in_dir    0 = MSB first, 1 = LSB first
//   in_len    number of bits to send (clamped to W by the controller)
//   in_div    bit period minus one, in clk cycles
// Modports: master = upstream producer, slave = controller.
// ---------------------------------------------------------------------------
interface shft_ser_ctrl_if
    import shft_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DIV_W = 8,
    localparam int CW    = len_width(W)
);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_dir;
    logic [CW-1:0]    in_len;
    logic [DIV_W-1:0] in_div;

    modport master (
        output in_valid,
        output in_data,
        output in_dir,
        output in_len,
        output in_div,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dir,
        input  in_len,
        input  in_div,
        output in_ready
    );

endinterface

// File: rtl/shft_tick_div.sv
// ---------------------------------------------------------------------------
// shft_tick_div
// Bit-period divider: a loadable down-counter that ticks when it reaches 0
// and then reloads from div, so each period lasts div+1 enabled cycles.
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   load   preload the counter with div (frame start)
//   en     count this cycle
//   div    period minus one
//   tick   high on the enabled cycle where the counter is 0
// ---------------------------------------------------------------------------
module shft_tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && (div_cnt == '0);

    // Reload on reaching 0 rather than wrapping, so an all-ones div gives a
    // 2^DIV_W period without ever needing a wider counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (load) begin
            div_cnt <= div;
        end else if (en) begin
            if (div_cnt == '0) begin
                div_cnt <= div;
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/shft_ser_ctrl.sv
// ---------------------------------------------------------------------------
// shft_ser_ctrl
// Serializer controller in front of a W-bit universal shift register.
// Takes a word over a valid/ready handshake, loads it into the register,
// then shifts it out one bit every div+1 cycles and pulses done at the end.
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   up           upstream handshake (slave side of shft_ser_ctrl_if)
//   sr_en        shift register enable
//   sr_load_sel  shift register parallel-load select
//   sr_dir_sel   shift register direction (captured dir)
//   sr_p_in      parallel load value (captured data)
//   sr_q         shift register contents
//   ser_out      current serial bit
//   ser_valid    ser_out is meaningful
//   busy         frame in progress
//   done         one-cycle frame-complete pulse
// ---------------------------------------------------------------------------
module shft_ser_ctrl
    import shft_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DIV_W = 8,
    localparam int CW    = len_width(W)
) (
    input  logic                  clk,
    input  logic                  reset,
    shft_ser_ctrl_if.slave        up,
    output logic                  sr_en,
    output logic                  sr_load_sel,
    output logic                  sr_dir_sel,
    output logic [W-1:0]          sr_p_in,
    input  logic [W-1:0]          sr_q,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  busy,
    output logic                  done
);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     data_q;
    logic             dir_q;
    logic [CW-1:0]    len_q;
    logic [DIV_W-1:0] div_q;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    len_clamped;
    logic             accept;
    logic             tick;
    logic             last_bit;
    logic             sr_q_unused;

    // Only the two end bits of the register are ever presented; the rest
    // are folded here so the full bus stays connected.
    assign sr_q_unused = ^sr_q;

    assign accept      = up.in_valid && up.in_ready;
    assign len_clamped = (up.in_len > CW'(W)) ? CW'(W) : up.in_len;
    assign last_bit    = (bit_cnt == (len_q - CW'(1)));

    shft_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .load  (state == LOAD),
        .en    (state == SHIFT),
        .div   (div_q),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame parameters are captured once on accept and frozen until the
    // next accept, so upstream changes mid-frame are invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            len_q  <= '0;
            div_q  <= '0;
        end else if (accept) begin
            data_q <= up.in_data;
            dir_q  <= up.in_dir;
            len_q  <= len_clamped;
            div_q  <= up.in_div;
        end
    end

    // Bit counter: cleared during LOAD, advanced on each shift tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state == LOAD) begin
            bit_cnt <= '0;
        end else if ((state == SHIFT) && tick && !last_bit) begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Next-state logic; a zero-length frame skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (len_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD:  state_nxt = SHIFT;
            SHIFT: begin
                if (tick && last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state; ser_out is the only output that
    // follows sr_q combinationally. in_ready is forced low while in reset.
    always_comb begin
        up.in_ready = (state == IDLE) && !reset;
        sr_en       = 1'b0;
        sr_load_sel = 1'b0;
        sr_dir_sel  = dir_q;
        sr_p_in     = data_q;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            LOAD: begin
                sr_en       = 1'b1;
                sr_load_sel = 1'b1;
            end
            SHIFT: begin
                sr_en     = tick;
                ser_valid = 1'b1;
                ser_out   = (dir_q == DIR_MSB_FIRST) ? sr_q[W-1] : sr_q[0];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
